// File: rtl/base2_log.sv
// Two-stage pipelined floor-log2 for 32-bit unsigned operands.
// Stage 1 finds per-byte MSB positions; stage 2 picks the highest nonzero byte.
module base2_log #(
    parameter int WIDTH = 32,
    parameter int LOG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] number_i,
    output logic             valid_o,
    output logic [LOG_W-1:0] log_o,
    output logic             zero_o
);

    localparam int NBYTES = WIDTH / 8;

    // Stage 1 state: one nonzero flag and one in-byte MSB index per byte
    logic [NBYTES-1:0]       nz_d, nz_q;
    logic [NBYTES-1:0][2:0]  pos_d, pos_q;
    logic                    valid1_d, valid1_q;

    // Stage 2 state: the registered outputs
    logic                    valid2_d, valid2_q;
    logic [LOG_W-1:0]        log_d, log_q;
    logic                    zero_d, zero_q;

    function automatic logic [2:0] msb_pos8(input logic [7:0] b);
        logic [2:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                r = 3'(k);
            end
        end
        return r;
    endfunction

    always_comb begin
        nz_d     = '0;
        pos_d    = '0;
        valid1_d = valid_i;
        for (int b = 0; b < NBYTES; b++) begin
            nz_d[b]  = |number_i[8*b +: 8];
            pos_d[b] = msb_pos8(number_i[8*b +: 8]);
        end
    end

    // Ascending scan so the highest nonzero byte wins; no byte set means a zero operand
    always_comb begin
        log_d    = '0;
        zero_d   = 1'b1;
        valid2_d = valid1_q;
        for (int b = 0; b < NBYTES; b++) begin
            if (nz_q[b]) begin
                log_d  = LOG_W'({2'(b), pos_q[b]});
                zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nz_q     <= '0;
            pos_q    <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            log_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            nz_q     <= nz_d;
            pos_q    <= pos_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            log_q    <= log_d;
            zero_q   <= zero_d;
        end
    end

    assign valid_o = valid2_q;
    assign log_o   = log_q;
    assign zero_o  = zero_q;

endmodule

// File: tb/tb_base2_log.sv
// Self-checking bench for base2_log: directed vector table, corner sequences,
// and randomized operands against a shift-count floor-log2 reference.
module tb_base2_log;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [31:0] number_i;
    logic        valid_o;
    logic [4:0]  log_o;
    logic        zero_o;

    int checks = 0;
    int errors = 0;

    // Expected-output delay line: p1 = entered last edge, p2 = due at the outputs now
    logic       p1_v, p2_v;
    logic [4:0] p1_l, p2_l;
    logic       p1_z, p2_z;

    typedef struct {
        logic        v;
        logic [31:0] n;
        logic [4:0]  l;
        logic        z;
    } vec_t;

    vec_t tbl[12];

    base2_log #(.WIDTH(32), .LOG_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .number_i (number_i),
        .valid_o  (valid_o),
        .log_o    (log_o),
        .zero_o   (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_out();
        chk("valid_o", {31'd0, valid_o}, {31'd0, p2_v});
        if (p2_v) begin
            chk("log_o", {27'd0, log_o}, {27'd0, p2_l});
            chk("zero_o", {31'd0, zero_o}, {31'd0, p2_z});
        end
    endtask

    task automatic clear_model();
        p1_v = 1'b0; p1_l = '0; p1_z = 1'b0;
        p2_v = 1'b0; p2_l = '0; p2_z = 1'b0;
    endtask

    // Present one operand for a cycle, then check the outputs due after the edge
    task automatic step(input logic v, input logic [31:0] n, input logic [4:0] l, input logic z);
        valid_i  = v;
        number_i = n;
        @(posedge clk);
        p2_v = p1_v; p2_l = p1_l; p2_z = p1_z;
        p1_v = v;    p1_l = l;    p1_z = z;
        #1;
        check_out();
    endtask

    // Reference: count right shifts until the value drops to 1
    task automatic ref_log(input logic [31:0] n, output logic [4:0] l, output logic z);
        logic [31:0] t;
        int cnt;
        t = n;
        cnt = 0;
        z = (n == 0);
        while (t > 1) begin
            t = t >> 1;
            cnt++;
        end
        l = 5'(cnt);
    endtask

    initial begin
        logic [4:0]  rl;
        logic        rz;
        logic [31:0] rn;
        logic [63:0] mask;
        int          len;
        logic        rv;

        tbl[0]  = '{1'b1, 32'h0000_0000, 5'd0,  1'b1};
        tbl[1]  = '{1'b1, 32'h0000_0001, 5'd0,  1'b0};
        tbl[2]  = '{1'b1, 32'h8000_0000, 5'd31, 1'b0};
        tbl[3]  = '{1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0};
        tbl[4]  = '{1'b1, 32'h7FFF_FFFF, 5'd30, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_00FF, 5'd7,  1'b0};
        tbl[6]  = '{1'b1, 32'h0000_0100, 5'd8,  1'b0};
        tbl[7]  = '{1'b1, 32'h0001_FFFF, 5'd16, 1'b0};
        tbl[8]  = '{1'b1, 32'h00FF_FFFF, 5'd23, 1'b0};
        tbl[9]  = '{1'b1, 32'h0100_0000, 5'd24, 1'b0};
        tbl[10] = '{1'b0, 32'h0000_0000, 5'd0,  1'b0};
        tbl[11] = '{1'b0, 32'h0000_0000, 5'd0,  1'b0};

        rst      = 1'b1;
        valid_i  = 1'b0;
        number_i = '0;
        clear_model();
        #1;
        chk("reset_valid_o", {31'd0, valid_o}, 32'd0);
        chk("reset_log_o", {27'd0, log_o}, 32'd0);
        chk("reset_zero_o", {31'd0, zero_o}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vector table, applied back to back
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].n, tbl[i].l, tbl[i].z);
        end

        // Walking one, then walking one with bit 0 also set
        for (int n = 0; n < 32; n++) begin
            step(1'b1, 32'd1 << n, 5'(n), 1'b0);
        end
        for (int n = 0; n < 32; n++) begin
            step(1'b1, (32'd1 << n) | 32'd1, 5'(n), 1'b0);
        end
        step(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b0);

        // Valid gaps: 1,0,1,1,0
        step(1'b1, 32'd5,          5'd2,  1'b0);
        step(1'b0, 32'hDEAD_BEEF,  5'd0,  1'b0);
        step(1'b1, 32'h0000_0400,  5'd10, 1'b0);
        step(1'b1, 32'd0,          5'd0,  1'b1);
        step(1'b0, 32'd3,          5'd1,  1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b0);

        // Reset with two valid operands in flight and a valid result on the outputs
        step(1'b1, 32'h0000_FFFF, 5'd15, 1'b0);
        step(1'b1, 32'h0010_0000, 5'd20, 1'b0);
        step(1'b1, 32'h0000_0300, 5'd9,  1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("midrst_log_o", {27'd0, log_o}, 32'd0);
        chk("midrst_zero_o", {31'd0, zero_o}, 32'd0);
        clear_model();
        valid_i  = 1'b1;
        number_i = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("inrst_valid_o", {31'd0, valid_o}, 32'd0);
        rst = 1'b0;
        step(1'b1, 32'h0000_0040, 5'd6, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b0);

        // Random operands biased toward a random bit length
        for (int i = 0; i < 10000; i++) begin
            rv  = ($urandom_range(0, 99) < 70);
            len = $urandom_range(0, 32);
            mask = (64'd1 << len) - 64'd1;
            rn = ($urandom() & mask[31:0]);
            if (len > 0) begin
                rn = rn | (32'd1 << (len - 1));
            end
            ref_log(rn, rl, rz);
            step(rv, rn, rl, rz);
        end
        step(1'b0, 32'd0, 5'd0, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
